// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer (master) and its PC, instruction
// register and memory environment (slave).
interface fetch_sequencer_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic              abort;
   logic [15:0]       instr;
   logic [ADDR_W-1:0] pc_addr;
   logic              zero_flag;
   logic              mem_ready;
   logic              pc_en;
   logic              pc_inc;
   logic              pc_w_en;
   logic [31:0]       pc_data;
   logic              pc_complete;
   logic              ir_load;
   logic              mem_req;
   logic              mem_we;
   logic              busy;
   logic [1:0]        err;
   logic [15:0]       instr_count;

   modport master (
      input  start, abort, instr, pc_addr, zero_flag, mem_ready,
      output pc_en, pc_inc, pc_w_en, pc_data, pc_complete, ir_load,
             mem_req, mem_we, busy, err, instr_count
   );

   modport slave (
      output start, abort, instr, pc_addr, zero_flag, mem_ready,
      input  pc_en, pc_inc, pc_w_en, pc_data, pc_complete, ir_load,
             mem_req, mem_we, busy, err, instr_count
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: steps a small instruction set through
// FETCH, DECODE, EXEC and MEMWAIT, driving PC strobes and memory requests.
module fetch_sequencer #(
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEMWAIT,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ALU   = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_JMP   = 4'h4;
   localparam logic [3:0] OP_JZ    = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t            state;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] target_q;
   logic [7:0]        wait_cnt;
   logic              pc_en_q;
   logic [1:0]        err_q;
   logic [15:0]       count_q;

   logic inc_c;
   logic wen_c;
   logic req_c;
   logic we_c;
   logic ir_c;
   logic legal_op;
   logic pc_at_top;
   logic unused_instr_bits;

   assign pc_at_top         = &bus.pc_addr;
   assign unused_instr_bits = ^bus.instr[11:ADDR_W];

   always_comb begin
      legal_op = 1'b0;
      case (bus.instr[15:12])
         OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_JMP, OP_JZ, OP_HALT: legal_op = 1'b1;
         default: legal_op = 1'b0;
      endcase
   end

   // Strobes are decoded live so that abort and zero_flag act in the same cycle;
   // reset also silences them so an abandoned operation emits nothing further.
   always_comb begin
      inc_c = 1'b0;
      wen_c = 1'b0;
      req_c = 1'b0;
      we_c  = 1'b0;
      ir_c  = 1'b0;
      if (!rst && !bus.abort) begin
         case (state)
            S_FETCH: ir_c = 1'b1;
            S_EXEC: begin
               case (op_q)
                  OP_NOP, OP_ALU: inc_c = 1'b1;
                  OP_JMP:         wen_c = 1'b1;
                  OP_JZ: begin
                     wen_c = bus.zero_flag;
                     inc_c = !bus.zero_flag;
                  end
                  OP_LOAD:  req_c = 1'b1;
                  OP_STORE: begin
                     req_c = 1'b1;
                     we_c  = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEMWAIT: begin
               req_c = 1'b1;
               we_c  = (op_q == OP_STORE);
               inc_c = bus.mem_ready;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= 4'h0;
         target_q <= '0;
         wait_cnt <= 8'd0;
         pc_en_q  <= 1'b0;
         err_q    <= 2'd0;
         count_q  <= 16'd0;
      end else begin
         if ((inc_c || wen_c) && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
         end
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state   <= S_FETCH;
                  pc_en_q <= 1'b1;
               end
            end
            S_FETCH: state <= bus.abort ? S_HALT : S_DECODE;
            S_DECODE: begin
               if (bus.abort) begin
                  state <= S_HALT;
               end else if (!legal_op) begin
                  state <= S_HALT;
                  err_q <= 2'd1;
               end else begin
                  op_q     <= bus.instr[15:12];
                  target_q <= bus.instr[ADDR_W-1:0];
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (bus.abort) begin
                  state <= S_HALT;
               end else begin
                  case (op_q)
                     OP_LOAD, OP_STORE: begin
                        state    <= S_MEMWAIT;
                        wait_cnt <= 8'd0;
                     end
                     OP_HALT: begin
                        state <= S_HALT;
                        err_q <= 2'd0;
                     end
                     default: begin
                        if (inc_c && pc_at_top) begin
                           state <= S_HALT;
                           err_q <= 2'd3;
                        end else begin
                           state <= S_FETCH;
                        end
                     end
                  endcase
               end
            end
            // The increment at the top address is still issued; only the next state changes.
            S_MEMWAIT: begin
               if (bus.abort) begin
                  state <= S_HALT;
               end else if (bus.mem_ready) begin
                  if (pc_at_top) begin
                     state <= S_HALT;
                     err_q <= 2'd3;
                  end else begin
                     state <= S_FETCH;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= S_HALT;
                  err_q <= 2'd2;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.pc_en       = pc_en_q;
   assign bus.pc_inc      = inc_c;
   assign bus.pc_w_en     = wen_c;
   assign bus.pc_data     = wen_c ? {{(32-ADDR_W){1'b0}}, target_q} : 32'd0;
   assign bus.pc_complete = (state == S_HALT);
   assign bus.ir_load     = ir_c;
   assign bus.mem_req     = req_c;
   assign bus.mem_we      = we_c;
   assign bus.busy        = (state != S_IDLE) && (state != S_HALT);
   assign bus.err         = err_q;
   assign bus.instr_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: program-counter address width.
REQ-002 Parameter TIMEOUT, default 15: maximum MEMWAIT cycles before timeout, range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: begin execution; sampled in IDLE only.
REQ-006 Port abort, input, 1: force HALT from any non-IDLE state.
REQ-007 Port instr, input, 16: instruction register contents; opcode [15:12], target [ADDR_W-1:0].
REQ-008 Port pc_addr, input, ADDR_W: current program-counter value.
REQ-009 Port zero_flag, input, 1: ALU zero result, used by JZ.
REQ-010 Port mem_ready, input, 1: memory access complete.
REQ-011 Port pc_en, output, 1: PC enable; a rising edge arms the PC.
REQ-012 Port pc_inc, output, 1: PC increment strobe.
REQ-013 Port pc_w_en, output, 1: PC load strobe.
REQ-014 Port pc_data, output, 32: PC load value; zero-extended target.
REQ-015 Port pc_complete, output, 1: freeze PC.
REQ-016 Port ir_load, output, 1: instruction register load strobe.
REQ-017 Port mem_req, output, 1: memory request.
REQ-018 Port mem_we, output, 1: memory write, valid with mem_req.
REQ-019 Port busy, output, 1: high in every state except IDLE and HALT.
REQ-020 Port err, output, 2: halt cause; 0 none/HALT, 1 illegal opcode, 2 timeout, 3 address wrap.
REQ-021 Port instr_count, output, 16: retired-instruction count.

Function
REQ-022 States SHALL be IDLE, FETCH, DECODE, EXEC, MEMWAIT and HALT, held in one registered state variable.
REQ-023 IDLE with start=1 SHALL go to FETCH on the next edge and set pc_en=1; pc_en then stays 1 until reset.
REQ-024 FETCH SHALL assert ir_load for exactly one cycle, then go to DECODE.
REQ-025 DECODE SHALL latch the opcode and target, then go to EXEC, or to HALT with err=1 for an illegal opcode.
REQ-026 Opcodes SHALL be 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 JMP, 5 JZ and F HALT; every other opcode is illegal.
REQ-027 EXEC for NOP or ALU SHALL assert pc_inc for one cycle, then go to FETCH (3 cycles per instruction).
REQ-028 EXEC for JMP SHALL assert pc_w_en with pc_data equal to the target, then go to FETCH.
REQ-029 EXEC for JZ SHALL assert pc_w_en if zero_flag=1 and pc_inc otherwise, sampling zero_flag in EXEC.
REQ-030 EXEC for LOAD or STORE SHALL assert mem_req (mem_we=1 for STORE), then go to MEMWAIT.
REQ-031 MEMWAIT SHALL hold mem_req and mem_we; the cycle that sees mem_ready=1 SHALL assert pc_inc combinationally and go to FETCH.
REQ-032 A MEMWAIT wait counter SHALL clear on entry; TIMEOUT consecutive cycles without mem_ready SHALL force HALT with err=2 and mem_req low.
REQ-033 EXEC for HALT SHALL go to HALT with err=0 and no PC strobe.
REQ-034 Any pc_inc issued while pc_addr equals all ones SHALL still be issued, and the sequencer then goes to HALT with err=3.
REQ-035 HALT SHALL hold pc_complete=1, with busy, mem_req, pc_inc, pc_w_en and ir_load at 0, until reset.
REQ-036 abort=1 in FETCH, DECODE, EXEC or MEMWAIT SHALL go to HALT on the next edge, suppress that cycle's PC strobes and memory request, and leave err unchanged.
REQ-037 Priority SHALL be rst over abort over normal sequencing.
REQ-038 start outside IDLE and abort in IDLE or HALT SHALL be ignored.
REQ-039 pc_inc and pc_w_en SHALL never be asserted in the same cycle.
REQ-040 instr_count SHALL increment by 1 on each cycle with pc_inc or pc_w_en, saturating at 16'hFFFF.
REQ-041 pc_data SHALL be 0 whenever pc_w_en is 0.

Reset
REQ-042 rst=1 at a clock edge SHALL force state=IDLE with every output 0, including pc_en, err and instr_count.
REQ-043 rst asserted mid-instruction or mid-MEMWAIT SHALL abandon the operation with no further strobes and no completion.
REQ-044 After rst is released, the sequencer SHALL wait in IDLE for a new start.

Verification
REQ-045 rst, start pulse, instr=0x1000 (ALU): ir_load in cycle 1, pc_inc in cycle 3, instr_count=1 after cycle 3, next ir_load in cycle 4.
REQ-046 instr=0x4025: pc_w_en=1 with pc_data=0x25 in EXEC; instr=0x5010 with zero_flag=0: pc_inc=1 and pc_w_en=0.
REQ-047 instr=0x3000, mem_ready high 4 cycles after MEMWAIT entry: mem_we=1 throughout, pc_inc in the mem_ready cycle; with mem_ready held low: HALT after 15 cycles, err=2.
REQ-048 instr=0x7000: HALT, err=1, pc_complete=1; instr=0xF000: HALT, err=0.
REQ-049 pc_addr=6'h3F with a NOP: pc_inc issued, then HALT with err=3; abort during MEMWAIT: HALT next cycle, mem_req=0.
REQ-050 rst pulsed during MEMWAIT: all outputs 0 next cycle, state IDLE; a later start restarts at FETCH.
